// File: rtl/stim_level_sweep_if.sv
// Control and status bundle for the stim level sweep sequencer.
// Carries sweep settings, generator feedback and sweep outputs.
interface stim_level_sweep_if #(
  parameter int LEVEL_W = 8,
  parameter int CNT_W   = 16
);
  logic               start;
  logic               abort;
  logic [LEVEL_W-1:0] start_level;
  logic [LEVEL_W-1:0] stop_level;
  logic [LEVEL_W-1:0] step;
  logic [CNT_W-1:0]   settle_cycles;
  logic [CNT_W-1:0]   pulses_per_step;
  logic               stim_drive_in;
  logic [LEVEL_W-1:0] level;
  logic               stim_enable;
  logic               busy;
  logic               done;
  logic [LEVEL_W-1:0] step_index;

  modport master (
    output start, abort, start_level, stop_level, step,
    output settle_cycles, pulses_per_step, stim_drive_in,
    input  level, stim_enable, busy, done, step_index
  );

  modport slave (
    input  start, abort, start_level, stop_level, step,
    input  settle_cycles, pulses_per_step, stim_drive_in,
    output level, stim_enable, busy, done, step_index
  );
endinterface

// File: rtl/stim_level_sweep.sv
// Steps the stim DAC level from start to stop, settling then
// counting generator pulses at each level before advancing.
module stim_level_sweep #(
  parameter int LEVEL_W = 8,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  stim_level_sweep_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_COUNT,
    S_ADVANCE,
    S_DONE
  } state_t;

  localparam int LW1 = LEVEL_W + 1;

  state_t             r_state, w_state;
  logic [LEVEL_W-1:0] r_level, w_level;
  logic [LEVEL_W-1:0] r_idx, w_idx;
  logic [LEVEL_W-1:0] r_stop, w_stop;
  logic [LEVEL_W-1:0] r_step, w_step;
  logic [CNT_W-1:0]   r_settle, w_settle;
  logic [CNT_W-1:0]   r_pps, w_pps;
  logic [CNT_W-1:0]   r_scnt, w_scnt;
  logic [CNT_W-1:0]   r_pcnt, w_pcnt;
  logic               r_dir_up, w_dir_up;
  logic               r_drv_q;

  logic [CNT_W-1:0]   w_settle_last;
  logic [CNT_W-1:0]   w_pps_last;
  logic [LW1-1:0]     w_diff;
  logic [LW1-1:0]     w_sum;
  logic               w_fall;
  logic               w_clamp;

  // zero settle/pulse settings behave as one
  assign w_settle_last = (r_settle == '0) ? '0 : r_settle - CNT_W'(1);
  assign w_pps_last    = (r_pps == '0) ? '0 : r_pps - CNT_W'(1);

  assign w_diff = r_dir_up ? {1'b0, r_stop} - {1'b0, r_level}
                           : {1'b0, r_level} - {1'b0, r_stop};
  assign w_sum  = r_dir_up ? {1'b0, r_level} + {1'b0, r_step}
                           : {1'b0, r_level} - {1'b0, r_step};
  assign w_clamp = (w_diff <= {1'b0, r_step}) | w_sum[LEVEL_W];

  // only falling edges count, so enable-induced rises never do
  assign w_fall = r_drv_q & ~bus.stim_drive_in;

  assign bus.level       = r_level;
  assign bus.step_index  = r_idx;
  assign bus.stim_enable = (r_state == S_COUNT);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = (r_state == S_DONE);

  // next-state and datapath updates; abort overrides everything
  always_comb begin
    w_state  = r_state;
    w_level  = r_level;
    w_idx    = r_idx;
    w_stop   = r_stop;
    w_step   = r_step;
    w_settle = r_settle;
    w_pps    = r_pps;
    w_scnt   = r_scnt;
    w_pcnt   = r_pcnt;
    w_dir_up = r_dir_up;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_stop   = bus.stop_level;
          w_step   = bus.step;
          w_settle = bus.settle_cycles;
          w_pps    = bus.pulses_per_step;
          w_level  = bus.start_level;
          w_idx    = '0;
          w_dir_up = (bus.stop_level >= bus.start_level);
          w_scnt   = '0;
          w_pcnt   = '0;
          w_state  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_scnt == w_settle_last) begin
          w_scnt  = '0;
          w_state = S_COUNT;
        end else begin
          w_scnt = r_scnt + CNT_W'(1);
        end
      end
      S_COUNT: begin
        if (w_fall) begin
          if (r_pcnt == w_pps_last) begin
            w_pcnt  = '0;
            w_state = S_ADVANCE;
          end else begin
            w_pcnt = r_pcnt + CNT_W'(1);
          end
        end
      end
      S_ADVANCE: begin
        if (r_idx != '1) w_idx = r_idx + LEVEL_W'(1);
        if (r_level == r_stop || r_step == '0) begin
          w_state = S_DONE;
        end else begin
          w_level = w_clamp ? r_stop : w_sum[LEVEL_W-1:0];
          w_state = S_SETTLE;
        end
      end
      S_DONE: w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
    if (bus.abort && r_state != S_IDLE) begin
      w_state = S_IDLE;
      w_level = r_level;
      w_idx   = r_idx;
      w_scnt  = '0;
      w_pcnt  = '0;
    end
  end

  // state, latched settings, counters and edge-detect register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_level  <= '0;
      r_idx    <= '0;
      r_stop   <= '0;
      r_step   <= '0;
      r_settle <= '0;
      r_pps    <= '0;
      r_scnt   <= '0;
      r_pcnt   <= '0;
      r_dir_up <= 1'b0;
      r_drv_q  <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_level  <= w_level;
      r_idx    <= w_idx;
      r_stop   <= w_stop;
      r_step   <= w_step;
      r_settle <= w_settle;
      r_pps    <= w_pps;
      r_scnt   <= w_scnt;
      r_pcnt   <= w_pcnt;
      r_dir_up <= w_dir_up;
      r_drv_q  <= bus.stim_drive_in;
    end
  end
endmodule

// File: doc/stim_level_sweep.md
Name: stim_level_sweep

Overview:
Sequencer that sits directly upstream of the stim pulse generator and drives its `enable` and `level` inputs. It steps the PWM DAC level from a start value to a stop value in programmable increments. At each level it holds the generator disabled for a DAC-filter settle time, then enables it for a fixed number of stim pulses. It counts those pulses by monitoring the generator's `stim_drive` output, which this block receives as `stim_drive_in`.

Parameters:
LEVEL_W, 8, width of level/step values (matches the generator's level input)
CNT_W, 16, width of settle-cycle and pulse-count fields

Ports:
clk  input  1  system clock (100 MHz domain shared with the stim generator)
rst_n  input  1  reset, asynchronous assert, active-low
start  input  1  single-cycle request to begin a sweep; ignored while busy
abort  input  1  single-cycle request to terminate the sweep
start_level  input  LEVEL_W  first level applied
stop_level  input  LEVEL_W  final level applied
step  input  LEVEL_W  level increment magnitude; direction is derived from start/stop
settle_cycles  input  CNT_W  clocks with stim disabled after each level change
pulses_per_step  input  CNT_W  stim pulses counted at each level
stim_drive_in  input  1  stim_drive output from the generator
level  output  LEVEL_W  level value to the generator
stim_enable  output  1  enable to the generator
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse on normal completion
step_index  output  LEVEL_W  number of levels fully completed in the current or last sweep

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; level=0; stim_enable=0; busy=0; done=0; step_index=0.
  - All internal counters cleared; drv_q (registered stim_drive_in) cleared to 0.
- Start in IDLE:
  - Latch start_level, stop_level, step, settle_cycles and pulses_per_step. Later input changes have no effect until the next start.
  - Set level=start_level, step_index=0, dir_up=(stop_level>=start_level).
  - Go to SETTLE next cycle.
- States and transitions:
  - IDLE: stim_enable=0. start -> SETTLE.
  - SETTLE:
    - stim_enable=0; settle counter increments each clock.
    - When count==settle_cycles-1 -> COUNT. settle_cycles=0 is treated as 1.
  - COUNT:
    - stim_enable=1.
    - A pulse is counted on a falling edge: drv_q==1 and stim_drive_in==0 in the same cycle.
    - The rising stim_drive caused by enable assertion is never counted.
    - When the pulse count reaches pulses_per_step (0 is treated as 1) -> ADVANCE.
  - ADVANCE:
    - Lasts one cycle; stim_enable=0; step_index+=1.
    - If level==stop_level or step==0 -> DONE.
    - Else level moves toward stop_level by step, clamped: if |stop_level-level|<=step then level=stop_level, else level +/- step. Then -> SETTLE.
  - DONE: done=1 for exactly one cycle, then -> IDLE.
- Arithmetic:
  - Level math uses LEVEL_W+1 bits, so no wrap-around at 0 or 2^LEVEL_W-1.
  - step_index saturates at all-ones.
- level is registered and changes only in the ADVANCE cycle or on start, never while stim_enable=1.
- Outputs hold their last values in IDLE after completion.
- abort (any non-IDLE state):
  - Next state is IDLE; stim_enable=0 on the next clock; done is not pulsed.
  - level and step_index hold.
  - abort takes priority over every other transition; abort in IDLE has no effect.
- start and abort asserted in the same IDLE cycle: start wins, since abort in IDLE is a no-op.
- start while busy: ignored.
- Reset mid-sweep: all outputs return to their reset values immediately.
- stim_drive_in is synchronous to clk; no synchronizer is required.

Test Plan:
- Up-sweep:
  - Stimulus: start_level=10, stop_level=40, step=10, settle_cycles=5, pulses_per_step=3, with the generator at rate=7.
  - Required: level sequence 10,20,30,40, each applied before stim_enable rises; stim_enable low exactly 5 clocks after each change; 3 falling edges counted per level; done pulses once; step_index=4.
- Down-sweep with clamping:
  - Stimulus: start_level=50, stop_level=5, step=20.
  - Required: levels 50,30,10,5, then done; no underflow.
- Degenerate settings:
  - Stimulus: step=0, start_level=100, stop_level=200.
  - Required: only level 100 is run, then done with step_index=1.
  - Stimulus: pulses_per_step=0, settle_cycles=0.
  - Required: behaves as if both were 1.
- Abort mid-COUNT:
  - Stimulus: abort after 1 of 3 pulses at level 20.
  - Required: stim_enable=0 the next cycle, busy=0, no done pulse, level holds 20.
- Edge qualification:
  - Check: stim_enable rising while the generator output is high is not counted.
  - Stimulus: assert start while busy.
  - Required: the start is ignored and the latched parameters are unchanged.
- Async reset:
  - Stimulus: drop rst_n mid-SETTLE with no clock edge.
  - Required: level=0, stim_enable=0, busy=0 immediately.
